// File: rtl/spi_cfg_controller.sv
`default_nettype none
// ============================================================================
// spi_cfg_controller: write-only 16-bit SPI frame generator, 2-way round-robin
// arbiter; SPI_CFG_ADDR_CHECK_EN rejects addresses above MAX_ADDR.  Rev 1.0
// ============================================================================
module spi_cfg_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int MAX_ADDR   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       last_grant
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] PER_LAST  = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(GAP_CYCLES - 1);
`ifdef SPI_CFG_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  state_t      state;
  logic [8:0]  cnt;
  logic [4:0]  fall_cnt;
  logic [14:0] shreg;     // frame bits 14..0; bit 15 (write flag) is always 1
  logic        ptr;
  logic        grant_any;
  logic        grant_id;
  logic [6:0]  g_addr;
  logic [7:0]  g_data;
  logic        addr_bad;

  always_comb begin
    grant_id = ptr;
    if (req0_valid && !req1_valid)
      grant_id = 1'b0;
    else if (req1_valid && !req0_valid)
      grant_id = 1'b1;
    grant_any = (state == IDLE) && (req0_valid || req1_valid);
    g_addr    = grant_id ? req1_addr : req0_addr;
    g_data    = grant_id ? req1_data : req0_data;
    addr_bad  = CHECK_EN && (int'(g_addr) > MAX_ADDR);
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any && grant_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      fall_cnt   <= '0;
      shreg      <= '0;
      ptr        <= 1'b0;
      SCLK       <= 1'b0;
      COPI       <= 1'b0;
      nCS        <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            ptr        <= ~grant_id;
            last_grant <= grant_id;
            if (addr_bad) begin
              err <= 1'b1;
            end else begin
              shreg <= {g_addr, g_data};
              COPI  <= 1'b1;
              nCS   <= 1'b0;
              busy  <= 1'b1;
              cnt   <= '0;
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            fall_cnt <= '0;
            SCLK     <= 1'b1;
            state    <= SHIFT;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        SHIFT: begin
          cnt <= cnt + 9'd1;
          // After the 16th fall the shifter is all zeros, which parks COPI low.
          if (cnt == HALF_LAST) begin
            SCLK     <= 1'b0;
            COPI     <= shreg[14];
            shreg    <= {shreg[13:0], 1'b0};
            fall_cnt <= fall_cnt + 5'd1;
          end else if (cnt == PER_LAST) begin
            cnt <= '0;
            if (fall_cnt == 5'd16)
              state <= HOLD;
            else
              SCLK <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            nCS   <= 1'b1;
            done  <= 1'b1;
            state <= GAP;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_controller.sv
`default_nettype none
// Self-checking bench for spi_cfg_controller: cycle model of all outputs plus a
// frame scoreboard, driven by a vector table and a few hand-written sequences.
module tb_spi_cfg_controller;

  localparam int CD   = 4;
  localparam int GP   = 8;
  localparam int MAXA = 4;
  localparam int MW0  = 34 * CD + GP;   // busy cycles after an accepted frame
`ifdef SPI_CFG_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [6:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       SCLK, COPI, nCS, busy, done, err, last_grant;

  always #5 clk = ~clk;

  spi_cfg_controller #(.CLK_DIV(CD), .GAP_CYCLES(GP), .MAX_ADDR(MAXA)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .SCLK(SCLK), .COPI(COPI), .nCS(nCS), .busy(busy), .done(done), .err(err),
    .last_grant(last_grant)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- cycle model + scoreboard ----------------
  int          mw = 0;
  logic        mptr = 1'b0, mlg = 1'b0, merr_next = 1'b0;
  logic [15:0] mf = '0, cap = '0, cap_last = '0, exp_f;
  logic [15:0] sbq[$];
  int          ncap = 0, done_cnt = 0, ncs_low_cnt = 0, err_cnt = 0;
  logic        psclk = 1'b0;

  always @(negedge clk) begin
    int k, t, idx;
    logic e_ncs, e_sclk, e_copi, e_busy, e_done, e_err, e_r0, e_r1, g, acc;
    if (!rst_n) begin
      mw = 0; mptr = 1'b0; mlg = 1'b0; merr_next = 1'b0;
      sbq.delete(); ncap = 0; cap = '0; psclk = 1'b0;
    end else begin
      e_busy = (mw > 0);
      e_ncs  = !(mw > GP);
      e_done = (mw == GP);
      e_err  = merr_next;
      merr_next = 1'b0;
      e_sclk = 1'b0;
      e_copi = 1'b0;
      if (mw > GP) begin
        k      = MW0 + 1 - mw;
        t      = k - 1 - CD;
        e_sclk = (t >= 0) && (t < 32 * CD) && ((t % (2 * CD)) < CD);
        idx    = (k - 1) / (2 * CD);
        e_copi = (idx <= 15) ? mf[15 - idx] : 1'b0;
      end
      e_r0 = 1'b0; e_r1 = 1'b0; acc = 1'b0; g = mptr;
      if (mw > 0) begin
        mw--;
      end else if (req0_valid || req1_valid) begin
        acc  = 1'b1;
        g    = (req0_valid && req1_valid) ? mptr : req1_valid;
        e_r0 = !g;
        e_r1 = g;
      end
      check("outputs{ncs,sclk,copi,busy,done,err,rdy0,rdy1,lg}",
            {nCS, SCLK, COPI, busy, done, err, req0_ready, req1_ready, last_grant},
            {e_ncs, e_sclk, e_copi, e_busy, e_done, e_err, e_r0, e_r1, mlg});
      if (acc) begin
        mptr = !g;
        mlg  = g;
        mf   = g ? {1'b1, req1_addr, req1_data} : {1'b1, req0_addr, req0_data};
        if (CHK && (int'(mf[14:8]) > MAXA)) merr_next = 1'b1;
        else begin mw = MW0; sbq.push_back(mf); end
      end
      if (!nCS && SCLK && !psclk) begin cap = {cap[14:0], COPI}; ncap++; end
      if (!nCS) ncs_low_cnt++;
      if (err) err_cnt++;
      if (done) begin
        check("sb_pending", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          exp_f = sbq.pop_front();
          check("frame", cap, exp_f);
        end
        check("sclk_rises", ncap, 16);
        cap_last = cap;
        ncap = 0;
        done_cnt++;
      end
      psclk = SCLK;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic v0; logic [6:0] a0; logic [7:0] d0;
    logic v1; logic [6:0] a1; logic [7:0] d1;
    logic first;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(input vec_t v, input string nm);
    int first, last;
    logic r0, r1;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    first = -1; last = -1;
    for (int c = 0; c < 2000 && (req0_valid || req1_valid); c++) begin
      @(negedge clk);
      r0 = req0_ready; r1 = req1_ready;
      @(posedge clk); #1;
      if (r0) begin if (first < 0) first = 0; last = 0; req0_valid = 1'b0; end
      if (r1) begin if (first < 0) first = 1; last = 1; req1_valid = 1'b0; end
    end
    check({nm, "_timeout"}, 32'(req0_valid || req1_valid), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check({nm, "_first"}, first, 32'(v.first));
    check({nm, "_last_grant"}, 32'(last_grant), last);
  endtask

  task automatic wait_done(input string nm);
    int c;
    for (c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done) break;
    end
    check({nm, "_done_timeout"}, 32'(c < 2000), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int   nacc, cyc, rises, dsnap, nsnap, esnap;
    int   ids[4], times[4];
    logic r0, r1, ps;

    tbl[0] = '{1'b1, 7'd0, 8'hFF, 1'b1, 7'd1, 8'h0F, 1'b0};
    tbl[1] = '{1'b0, 7'd0, 8'h00, 1'b1, 7'd2, 8'h5A, 1'b1};
    tbl[2] = '{1'b1, 7'd4, 8'h80, 1'b0, 7'd0, 8'h00, 1'b0};
    tbl[3] = '{1'b1, 7'd3, 8'h11, 1'b1, 7'd4, 8'h22, 1'b1};
    tbl[4] = '{1'b1, 7'd1, 8'hA5, 1'b1, 7'd0, 8'h3C, 1'b1};
    tbl[5] = '{1'b1, 7'd0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_state", {nCS, SCLK, COPI, busy, done, err, req0_ready, req1_ready, last_grant},
          9'b1_0000_0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // req1 held valid while req0 keeps requesting: grants alternate, 145 apart
    req1_valid = 1'b1; req1_addr = 7'd2; req1_data = 8'h77;
    req0_valid = 1'b1; req0_addr = 7'd3; req0_data = 8'h10;
    nacc = 0; cyc = 0;
    for (int c = 0; c < 3000 && nacc < 4; c++) begin
      @(negedge clk);
      r0 = req0_ready; r1 = req1_ready; cyc++;
      if (r0 || r1) begin ids[nacc] = 32'(r1); times[nacc] = cyc; nacc++; end
      @(posedge clk); #1;
      if (r0) req0_data = req0_data + 8'd1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("alt_count", nacc, 4);
    for (int i = 0; i < 4; i++) check($sformatf("alt_id%0d", i), ids[i], 32'(~i & 1));
    for (int i = 1; i < 4; i++) check($sformatf("alt_gap%0d", i), times[i] - times[i-1], 145);

    // request withdrawn during the gap: no frame, pointer untouched
    wait_done("alt");
    dsnap = done_cnt; nsnap = ncs_low_cnt;
    req0_valid = 1'b1; req0_addr = 7'd3; req0_data = 8'hEE;
    repeat (3) @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("withdraw_no_frame", ncs_low_cnt - nsnap, 0);
    check("withdraw_no_done", done_cnt - dsnap, 0);
    run_vec('{1'b1, 7'd1, 8'h66, 1'b1, 7'd3, 8'h99, 1'b1}, "withdraw_ptr");
    wait_done("withdraw");

    // out-of-range address
    nsnap = ncs_low_cnt; esnap = err_cnt;
    run_vec('{1'b1, 7'd5, 8'h9C, 1'b0, 7'd0, 8'h00, 1'b0}, "badaddr");
    if (CHK) begin
      repeat (200) @(posedge clk);
      #1;
      check("badaddr_ncs_idle", ncs_low_cnt - nsnap, 0);
      check("badaddr_err_pulses", err_cnt - esnap, 1);
    end else begin
      wait_done("badaddr");
      check("badaddr_frame", cap_last, 16'h859C);
      check("badaddr_no_err", err_cnt - esnap, 0);
    end

    // reset asserted at the 7th SCLK rise of a frame
    run_vec('{1'b1, 7'd3, 8'hC3, 1'b0, 7'd0, 8'h00, 1'b0}, "rst_frame");
    rises = 0; ps = SCLK;
    for (int c = 0; c < 500 && rises < 7; c++) begin
      @(negedge clk);
      if (SCLK && !ps) rises++;
      ps = SCLK;
    end
    check("rst_rise_count", rises, 7);
    dsnap = done_cnt;
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", {nCS, SCLK, COPI, busy, done, last_grant}, 6'b100000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("rst_no_done", done_cnt - dsnap, 0);
    run_vec('{1'b1, 7'd2, 8'h3C, 1'b1, 7'd1, 8'h55, 1'b0}, "post_rst");
    check("post_rst_frame0", cap_last, 16'h823C);
    wait_done("post_rst");
    check("post_rst_frame1", cap_last, 16'h8155);

    repeat (20) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
